// File: rtl/risc5_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc5_mem_pkg
//  Purpose  : Shared types, lane constants and address helpers for the
//             RISC5 memory-side blocks (external SRAM controller).
//  Revision : 1.0 - initial release
// ============================================================================
package risc5_mem_pkg;

  // Controller sequencing: setup cycle then strobe cycles, per halfword
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LO_SET = 3'd1,
    ST_LO_STB = 3'd2,
    ST_HI_SET = 3'd3,
    ST_HI_STB = 3'd4
  } state_t;

  // Byte lane within a halfword (HI = bits 15:8, the ub lane)
  localparam logic c_LANE_LO = 1'b0;
  localparam logic c_LANE_HI = 1'b1;

  // Halfword address of an access: words start at their even halfword,
  // bytes use the halfword that contains them
  function automatic logic [18:0] halfword_of(input logic [19:0] adr,
                                              input logic        is_byte);
    return is_byte ? adr[19:1] : {adr[19:2], 1'b0};
  endfunction

  // Lane holding a byte address
  function automatic logic byte_lane(input logic [19:0] adr);
    return adr[0] ? c_LANE_HI : c_LANE_LO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc5_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : risc5_sram_ctrl_if
//  Purpose  : Core-side request/response bus of the SRAM controller.
//             master = core, slave = memory controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface risc5_sram_ctrl_if;
  logic [19:0] adr;
  logic        rd;
  logic        wr;
  logic        ben;
  logic        fetch;
  logic [31:0] outbus;
  logic [31:0] inbus;
  logic        stallX;

  modport master (output adr, rd, wr, ben, fetch, outbus,
                  input  inbus, stallX);
  modport slave  (input  adr, rd, wr, ben, fetch, outbus,
                  output inbus, stallX);
endinterface
`default_nettype wire

// File: rtl/risc5_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : risc5_sram_ctrl
//  Purpose  : Executes RISC5 data/fetch requests on a 16-bit asynchronous
//             SRAM as one (byte) or two (word) halfword accesses, stalling
//             the core until the read data is on inbus.
//  Revision : 1.0 - initial release
// ============================================================================
module risc5_sram_ctrl
  import risc5_mem_pkg::*;
#(
  parameter int WAIT    = 1,     // strobe cycles per halfword, >= 1
  parameter bit IDLE_OE = 1'b0   // 1 = hold sram_oe_n low while idle
) (
  input  wire logic         clk,
  input  wire logic         rst,
  risc5_sram_ctrl_if.slave  bus,
  output logic [18:0]       sram_adr,
  output logic [15:0]       sram_dq_out,
  input  wire logic [15:0]  sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int CW = $clog2(WAIT + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wr;
  logic          r_ben;
  logic          r_lane;
  logic [15:0]   r_whi;
  logic [15:0]   r_lo;
  logic [31:0]   r_inbus;
  logic [18:0]   r_sram_adr;
  logic [15:0]   r_dq_out;
  logic          r_dq_oe;
  logic          r_ce_n;
  logic          r_oe_n;
  logic          r_we_n;
  logic          r_ub_n;
  logic          r_lb_n;

  logic          w_req;
  logic          w_acc_ben;
  logic          w_acc_lane;
  logic [18:0]   w_acc_hw;
  logic          w_last;

  assign w_req      = bus.rd | bus.wr | bus.fetch;
  // A pure fetch is always a word read; ben only qualifies rd/wr
  assign w_acc_ben  = (bus.rd | bus.wr) & bus.ben;
  assign w_acc_lane = byte_lane(bus.adr);
  assign w_acc_hw   = halfword_of(bus.adr, w_acc_ben);
  assign w_last     = (r_cnt == CW'(WAIT - 1));

  // Stall rises combinationally in the accept cycle so the core freezes at once
  assign bus.stallX = (r_state != ST_IDLE) |
                      ((r_state == ST_IDLE) & w_req & ~rst);
  assign bus.inbus  = r_inbus;

  assign sram_adr    = r_sram_adr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_ub_n   = r_ub_n;
  assign sram_lb_n   = r_lb_n;

  // Access sequencer with registered SRAM strobes and read-data assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_ben      <= 1'b0;
      r_lane     <= c_LANE_LO;
      r_whi      <= '0;
      r_lo       <= '0;
      r_inbus    <= '0;
      r_sram_adr <= '0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= ~IDLE_OE;
      r_we_n     <= 1'b1;
      r_ub_n     <= 1'b1;
      r_lb_n     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            // wr outranks rd, rd outranks fetch
            r_wr       <= bus.wr;
            r_ben      <= w_acc_ben;
            r_lane     <= w_acc_lane;
            r_whi      <= bus.outbus[31:16];
            r_sram_adr <= w_acc_hw;
            r_ce_n     <= 1'b0;
            r_cnt      <= '0;
            if (w_acc_ben) begin
              r_ub_n <= ~(w_acc_lane == c_LANE_HI);
              r_lb_n <= ~(w_acc_lane == c_LANE_LO);
            end else begin
              r_ub_n <= 1'b0;
              r_lb_n <= 1'b0;
            end
            if (bus.wr) begin
              // oe_n goes high on the same edge the pads start driving
              r_oe_n   <= 1'b1;
              r_dq_oe  <= 1'b1;
              r_dq_out <= w_acc_ben ? {2{bus.outbus[7:0]}} : bus.outbus[15:0];
            end else begin
              r_oe_n   <= 1'b0;
              r_dq_oe  <= 1'b0;
            end
            r_state <= ST_LO_SET;
          end
        end

        ST_LO_SET, ST_HI_SET: begin
          r_we_n  <= ~r_wr;
          r_cnt   <= '0;
          r_state <= (r_state == ST_LO_SET) ? ST_LO_STB : ST_HI_STB;
        end

        ST_LO_STB: begin
          if (w_last) begin
            r_we_n <= 1'b1;
            if (r_ben) begin
              r_state <= ST_IDLE;
              r_ce_n  <= 1'b1;
              r_dq_oe <= 1'b0;
              r_oe_n  <= ~IDLE_OE;
              r_ub_n  <= 1'b1;
              r_lb_n  <= 1'b1;
              if (!r_wr) begin
                r_inbus <= {24'b0, (r_lane == c_LANE_HI) ? sram_dq_in[15:8]
                                                         : sram_dq_in[7:0]};
              end
            end else begin
              // Word base is even, so the upper half is base with bit 0 set
              if (!r_wr) r_lo <= sram_dq_in;
              r_sram_adr <= {r_sram_adr[18:1], 1'b1};
              r_dq_out   <= r_whi;
              r_state    <= ST_HI_SET;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_HI_STB: begin
          if (w_last) begin
            r_we_n  <= 1'b1;
            r_state <= ST_IDLE;
            r_ce_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_oe_n  <= ~IDLE_OE;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            if (!r_wr) r_inbus <= {sram_dq_in, r_lo};
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_risc5_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc5_sram_ctrl
//  Purpose  : Directed self-checking bench for risc5_sram_ctrl with a
//             behavioural async SRAM; WAIT=1 and WAIT=3 instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_risc5_sram_ctrl;

  logic clk;
  logic rst;
  logic rst3;
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  risc5_sram_ctrl_if bus1 ();
  risc5_sram_ctrl_if bus3 ();

  logic [18:0] sa1, sa3;
  logic [15:0] dqo1, dqo3, dqi1, dqi3;
  logic        oe1, oe3, ce1, ce3, oen1, oen3, we1, we3, ub1, ub3, lb1, lb3;

  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];

  risc5_sram_ctrl #(.WAIT(1), .IDLE_OE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .sram_adr(sa1), .sram_dq_out(dqo1), .sram_dq_in(dqi1), .sram_dq_oe(oe1),
    .sram_ce_n(ce1), .sram_oe_n(oen1), .sram_we_n(we1),
    .sram_ub_n(ub1), .sram_lb_n(lb1)
  );

  risc5_sram_ctrl #(.WAIT(3), .IDLE_OE(1'b0)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(bus3),
    .sram_adr(sa3), .sram_dq_out(dqo3), .sram_dq_in(dqi3), .sram_dq_oe(oe3),
    .sram_ce_n(ce3), .sram_oe_n(oen3), .sram_we_n(we3),
    .sram_ub_n(ub3), .sram_lb_n(lb3)
  );

  // Asynchronous SRAM models: read data only while selected and output-enabled
  assign dqi1 = (!ce1 && !oen1) ? mem1[sa1[7:0]] : 16'h0000;
  assign dqi3 = (!ce3 && !oen3) ? mem3[sa3[7:0]] : 16'h0000;

  // Lane-masked writes while ce_n and we_n are low and the bus is driven
  always @(posedge clk) begin
    if (!ce1 && !we1 && oe1) begin
      if (!lb1) mem1[sa1[7:0]][7:0]  = dqo1[7:0];
      if (!ub1) mem1[sa1[7:0]][15:8] = dqo1[15:8];
    end
    if (!ce3 && !we3 && oe3) begin
      if (!lb3) mem3[sa3[7:0]][7:0]  = dqo3[7:0];
      if (!ub3) mem3[sa3[7:0]][15:8] = dqo3[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the WAIT=1 instance and count stallX-high cycles
  task automatic req1(input logic w, input logic r, input logic f, input logic b,
                      input logic [19:0] a, input logic [31:0] d, output int cyc);
    bus1.wr = w; bus1.rd = r; bus1.fetch = f; bus1.ben = b;
    bus1.adr = a; bus1.outbus = d;
    cyc = 0;
    #1;
    while (bus1.stallX === 1'b1 && cyc < 40) begin
      tick();
      bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.fetch = 1'b0;
      #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h0000;
      mem3[i] = 16'h0000;
    end
    bus1.adr = '0; bus1.rd = 0; bus1.wr = 0; bus1.ben = 0; bus1.fetch = 0; bus1.outbus = '0;
    bus3.adr = '0; bus3.rd = 0; bus3.wr = 0; bus3.ben = 0; bus3.fetch = 0; bus3.outbus = '0;
    rst = 1'b1; rst3 = 1'b1;
    tick(); tick();
    rst = 1'b0; rst3 = 1'b0;
    tick(); tick();

    // ---- reset held 2 cycles while idle ----
    rst = 1'b1;
    tick(); tick();
    chk("rst_strobes", {28'b0, ce1, oen1, we1, ub1 & lb1}, 32'h0000000F);
    chk("rst_dq_oe",   {31'b0, oe1}, 32'h0);
    chk("rst_stall",   {31'b0, bus1.stallX}, 32'h0);
    chk("rst_inbus",   bus1.inbus, 32'h00000000);
    chk("rst_adr",     {13'b0, sa1}, 32'h0);
    rst = 1'b0;
    tick();

    // ---- word write 0x00104 <- 0x12345678 ----
    bus1.wr = 1; bus1.ben = 0; bus1.adr = 20'h00104; bus1.outbus = 32'h12345678;
    #1;
    chk("ww_stall_T", {31'b0, bus1.stallX}, 32'h1);
    tick();
    bus1.wr = 0;
    chk("ww_lo_adr",   {13'b0, sa1}, 32'h00082);
    chk("ww_lo_dq",    {16'b0, dqo1}, 32'h5678);
    chk("ww_lo_pins",  {27'b0, ce1, oen1, we1, ub1, lb1}, 32'b01100);
    chk("ww_lo_dqoe",  {31'b0, oe1}, 32'h1);
    tick();
    chk("ww_lo_we",    {31'b0, we1}, 32'h0);
    tick();
    chk("ww_hi_adr",   {13'b0, sa1}, 32'h00083);
    chk("ww_hi_dq",    {16'b0, dqo1}, 32'h1234);
    chk("ww_hi_we1",   {31'b0, we1}, 32'h1);
    tick();
    chk("ww_hi_we",    {31'b0, we1}, 32'h0);
    chk("ww_stall_T4", {31'b0, bus1.stallX}, 32'h1);
    tick();
    chk("ww_stall_T5", {31'b0, bus1.stallX}, 32'h0);
    chk("ww_done_pins", {29'b0, ce1, we1, oe1}, 32'b110);
    chk("ww_mem_lo",   {16'b0, mem1[8'h82]}, 32'h5678);
    chk("ww_mem_hi",   {16'b0, mem1[8'h83]}, 32'h1234);

    // ---- word read ----
    mem1[8'h82] = 16'hBEEF; mem1[8'h83] = 16'hDEAD;
    req1(0, 1, 0, 0, 20'h00104, 32'h0, cyc);
    chk("wr_latency", cyc, 32'd5);
    chk("wr_inbus",   bus1.inbus, 32'hDEADBEEF);

    // ---- byte write 0x00107 <- 0xA5 (upper lane) ----
    bus1.wr = 1; bus1.ben = 1; bus1.adr = 20'h00107; bus1.outbus = 32'hFFFFFFA5;
    tick();
    bus1.wr = 0;
    chk("bw_adr",   {13'b0, sa1}, 32'h00083);
    chk("bw_lanes", {30'b0, ub1, lb1}, 32'b01);
    chk("bw_dq",    {16'b0, dqo1}, 32'hA5A5);
    tick();
    chk("bw_stall_T2", {31'b0, bus1.stallX}, 32'h1);
    tick();
    chk("bw_stall_T3", {31'b0, bus1.stallX}, 32'h0);
    chk("bw_mem",      {16'b0, mem1[8'h83]}, 32'hA5AD);
    chk("bw_inbus_kept", bus1.inbus, 32'hDEADBEEF);

    // ---- byte reads, back to back ----
    mem1[8'h83] = 16'h7F3C;
    req1(0, 1, 0, 1, 20'h00106, 32'h0, cyc);
    chk("br_latency", cyc, 32'd3);
    chk("br_inbus_lo", bus1.inbus, 32'h0000003C);
    req1(0, 1, 0, 1, 20'h00107, 32'h0, cyc);
    chk("br2_latency", cyc, 32'd3);
    chk("br2_inbus_hi", bus1.inbus, 32'h0000007F);

    // ---- instruction fetch (ben ignored, always word) ----
    mem1[8'h83] = 16'hDEAD;
    req1(0, 0, 1, 1, 20'h00104, 32'h0, cyc);
    chk("fe_latency", cyc, 32'd5);
    chk("fe_inbus",   bus1.inbus, 32'hDEADBEEF);

    // ---- WAIT=3: reset aborts a write during LO_STB ----
    bus3.wr = 1; bus3.ben = 0; bus3.adr = 20'h00010; bus3.outbus = 32'hCAFEF00D;
    tick();
    bus3.wr = 0;
    tick();
    chk("w3_we_low", {31'b0, we3}, 32'h0);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    #1;
    chk("w3_abort_pins", {29'b0, we3, ce3, oe3}, 32'b110);
    chk("w3_abort_stall", {31'b0, bus3.stallX}, 32'h0);
    chk("w3_abort_inbus", bus3.inbus, 32'h0);

    // ---- WAIT=3 word read latency ----
    mem3[8'h08] = 16'h4321; mem3[8'h09] = 16'h8765;
    tick();
    bus3.rd = 1; bus3.ben = 0; bus3.adr = 20'h00010;
    cyc = 0;
    #1;
    while (bus3.stallX === 1'b1 && cyc < 40) begin
      tick();
      bus3.rd = 0;
      #1;
      cyc++;
    end
    chk("w3_latency", cyc, 32'd9);
    chk("w3_inbus",   bus3.inbus, 32'h87654321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
